// File: rtl/sub32_pkg.sv
// Shared types and constants for the serial 32-bit subtractor.
// Holds the datapath width, FSM state type and counter sizing helper.
package sub32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter able to hold 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub32_serial_sub_digit.sv
// One DIGIT_W-bit subtract-with-borrow slice.
// Purely combinational: diff = x - y - bi, bo set on underflow.
module sub_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bi,
  output logic [DIGIT_W-1:0] diff,
  output logic               bo
);

  logic [DIGIT_W:0] full;

  // Extra top bit of the widened difference is the borrow-out
  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
    diff = full[DIGIT_W-1:0];
    bo   = full[DIGIT_W];
  end

endmodule

// File: rtl/sub32_serial.sv
// Serial 32-bit subtractor, DIGIT_W bits per clock, LSB first.
// Define SUB32_SERIAL_OVF_EN to add the signed overflow output ovf.
module sub32_serial
  import sub32_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              bin,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  d,
  output logic              bout
`ifdef SUB32_SERIAL_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = cnt_w(N);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   d_r;
  logic [WIDTH-1:0]   d_next;
  logic               brw;
  logic [DIGIT_W-1:0] diff;
  logic               bo;
  logic               last;

`ifdef SUB32_SERIAL_OVF_EN
  logic sa;
  logic sb;
  logic ovf_r;
`endif

  sub_digit #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .x   (a_r[DIGIT_W-1:0]),
    .y   (b_r[DIGIT_W-1:0]),
    .bi  (brw),
    .diff(diff),
    .bo  (bo)
  );

  assign last = (cnt == CW'(N - 1));

  // Result fills from the top so after N slices it is aligned
  generate
    if (DIGIT_W == WIDTH) begin : g_whole
      assign d_next = diff;
    end else begin : g_shift
      assign d_next = {diff, d_r[WIDTH-1:DIGIT_W]};
    end
  endgenerate

  // FSM with operand shifting, borrow chain and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      d_r   <= '0;
      brw   <= 1'b0;
`ifdef SUB32_SERIAL_OVF_EN
      sa    <= 1'b0;
      sb    <= 1'b0;
      ovf_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SUB32_SERIAL_OVF_EN
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r <= a_r >> DIGIT_W;
          b_r <= b_r >> DIGIT_W;
          brw <= bo;
          d_r <= d_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SUB32_SERIAL_OVF_EN
            ovf_r <= (sa ^ sb) & (diff[DIGIT_W-1] ^ sa);
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign d    = d_r;
  assign bout = brw;
`ifdef SUB32_SERIAL_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule

// File: doc/sub32_serial.md
SUB32_SERIAL -- requirements
Module: sub32_serial

Interface
REQ-001 Parameter DIGIT_W, default 4, bits processed per clock; SHALL be 1, 2, 4, 8, 16 or 32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only while idle or done.
REQ-005 a  input  32  minuend; captured on the accepted start edge.
REQ-006 b  input  32  subtrahend; captured on the accepted start edge.
REQ-007 bin  input  1  borrow-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 d  output  32  difference a - b - bin, mod 2^32.
REQ-011 bout  output  1  borrow-out: 1 iff a < b + bin, unsigned.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 captures a, b, bin, clears the digit counter, and moves to RUN.
REQ-014 RUN: each edge subtracts one DIGIT_W slice, LSB first, propagating borrow; the counter increments.
REQ-015 RUN moves to DONE on the edge that processes the last of N = 32/DIGIT_W slices.
REQ-016 Latency: done=1 exactly N edges after the accepting edge; DIGIT_W=4 gives 8 cycles.
REQ-017 DONE lasts one cycle: start=1 is accepted as in IDLE (back-to-back, RUN); otherwise the FSM returns to IDLE.
REQ-018 busy = (state == RUN); done = (state == DONE).
REQ-019 start during RUN is ignored, and a, b, bin changes during RUN do not affect the result.
REQ-020 d and bout hold their last result from DONE until the next accepted start.
REQ-021 d and bout are undefined-free but don't-care during RUN; the bench checks them only while done=1.
REQ-022 Boundaries: a=b with bin=0 -> d=0, bout=0; a=0, b=0, bin=1 -> d=32'hFFFFFFFF, bout=1.

Reset
REQ-023 rst_n=0 forces state=IDLE, busy=0, done=0, d=0, bout=0 and clears the counter and operand registers, immediately and regardless of clk.
REQ-024 Reset mid-RUN aborts the operation; no done pulse is produced for it.
REQ-025 The first start after rst_n returns high is accepted normally.

Configuration
REQ-026 Macro SUB32_SERIAL_OVF_EN defined: adds output ovf, 1 bit, equal to signed two's-complement overflow of a - b - bin.
REQ-027 ovf is valid with done, holds like d, and resets to 0.
REQ-028 Macro undefined: no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-029 Shared package sub32_pkg holds:
- WIDTH=32;
- state enum type (IDLE, RUN, DONE);
- the counter width function.
REQ-030 One sub-module, sub_digit: combinational DIGIT_W-bit subtract-with-borrow slice (x, y, bi -> diff, bo), instantiated once.

Verification
REQ-031 a=40, b=15, bin=1 -> after 8 cycles d=24, bout=0, done pulse of exactly 1 cycle.
REQ-032 a=5, b=35, bin=0 -> d=32'hFFFFFFE2, bout=1; with the macro, ovf=0.
REQ-033 With the macro, a=32'h80000000, b=1, bin=0 -> d=32'h7FFFFFFF, bout=0, ovf=1.
REQ-034 Start a=1000000, b=1; pulse start again and change a to 0 in cycle 3 -> single done, d=999999; second start ignored.
REQ-035 Back-to-back: start held high in DONE with a=100, b=200 -> immediate RUN, next d=32'hFFFFFF9C, bout=1.
REQ-036 rst_n low in RUN cycle 4 -> outputs 0, no done; a new start gives a correct result 8 cycles later.
